simple_mem_arbiter: RTL and testbench
=====================================

SIMPLE_MEM_ARBITER -- requirements
Module: simple_mem_arbiter

Interface
REQ-001 Parameter RAM_LAT, default 1: read latency of the shared RAM, in clk cycles (1..4).
REQ-002 Parameter STARVE_MAX, default 3: consecutive denied fetch cycles before fetch is forced to win.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port if_req, input, 1: fetch request.
REQ-006 Port if_addr, input, 16: fetch address.
REQ-007 Port if_stall, output, 1: fetch not granted this cycle.
REQ-008 Port if_valid, output, 1: if_rdata holds a valid fetch result.
REQ-009 Port if_rdata, output, 16: fetched word.
REQ-010 Port d_req, input, 1: data request.
REQ-011 Port d_we, input, 1: data request is a write.
REQ-012 Port d_addr, input, 16: data address.
REQ-013 Port d_wdata, input, 16: write data.
REQ-014 Port d_stall, output, 1: data request not granted this cycle.
REQ-015 Port d_valid, output, 1: data access completed (read data valid, or write acknowledged).
REQ-016 Port d_rdata, output, 16: read word.
REQ-017 Port ram_addr, output, 16: RAM address.
REQ-018 Port ram_wdata, output, 16: RAM write data.
REQ-019 Port ram_wren, output, 1: RAM write enable.
REQ-020 Port ram_q, input, 16: RAM read data, valid RAM_LAT cycles after the address is issued.

Function
REQ-021 The arbiter SHALL grant at most one requester per cycle; the grant is combinational from the requests and the starve state.
REQ-022 Default priority SHALL be data over fetch, except that fetch SHALL win when starve_cnt equals STARVE_MAX.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) in each cycle where if_req is high and fetch is denied, and SHALL clear on a fetch grant or when if_req is low.
REQ-024 Stall outputs SHALL be: if_stall = if_req & ~grant_if; d_stall = d_req & ~grant_d.
REQ-025 A stalled requester holds its request and operands stable; the arbiter SHALL NOT latch requests.
REQ-026 On a fetch grant, ram_addr SHALL equal if_addr and ram_wren SHALL be 0.
REQ-027 On a data grant, ram_addr SHALL equal d_addr, ram_wdata SHALL equal d_wdata, and ram_wren SHALL equal d_we.
REQ-028 With no grant, ram_wren SHALL be 0 and ram_addr SHALL hold its last granted value.
REQ-029 Each grant SHALL push a tag (NONE/IF/D) into a RAM_LAT-deep shift register, one entry per cycle; a no-grant cycle pushes NONE.
REQ-030 When the tag at the pipe output is IF, if_valid SHALL be 1 and if_rdata SHALL equal ram_q.
REQ-031 When the tag at the pipe output is D, d_valid SHALL be 1 and d_rdata SHALL equal ram_q; for a write, d_rdata is don't-care.
REQ-032 Each valid SHALL last exactly 1 cycle per grant.
REQ-033 Back-to-back grants SHALL be accepted every cycle: throughput 1 access/cycle, latency RAM_LAT.
REQ-034 If if_req and d_req are both high with starve_cnt < STARVE_MAX, data SHALL win and if_stall SHALL be 1.
REQ-035 A data write and a fetch to the same address in consecutive cycles SHALL be serviced in grant order, with no forwarding.

Reset
REQ-036 While rst_n is low, the tag pipe SHALL be all NONE, starve_cnt SHALL be 0, and ram_addr SHALL be 0.
REQ-037 While rst_n is low, if_valid, d_valid and ram_wren SHALL be 0, if_rdata and d_rdata SHALL be 0, and no grant SHALL issue.
REQ-038 Reset mid-operation SHALL discard all in-flight tags; no valid pulse SHALL follow the release of reset for an access issued before reset.

Structure
REQ-039 The tag encoding (TAG_NONE=0, TAG_IF=1, TAG_D=2) and the default values of RAM_LAT and STARVE_MAX SHALL reside in the shared simple_pkg package.
REQ-040 The tag delay line SHALL be a sub-module, arb_tag_pipe (parameter DEPTH, async reset to TAG_NONE).

Verification
REQ-041 Scenario: fetch only, if_addr=0x0010, RAM_LAT=1 -> if_stall=0 and ram_addr=0x0010 in the same cycle; if_valid=1 in the next cycle with if_rdata equal to mem[0x0010].
REQ-042 Scenario: if_req and d_req (read 0x0040) both high for 1 cycle -> d granted and if_stall=1; d_valid 1 cycle later; fetch granted in the following cycle.
REQ-043 Scenario: d_req held high for 6 cycles with if_req high, STARVE_MAX=3 -> fetch granted in cycle 4 (d_stall=1 in that cycle); data wins cycles 1-3 and 5-6.
REQ-044 Scenario: write 0x1234 to 0x0005, then read 0x0005 in the next cycle -> ram_wren=1 for 1 cycle, d_valid on both accesses, read returns 0x1234.
REQ-045 Scenario: RAM_LAT=3, grants IF,D,IF on consecutive cycles -> valids if,d,if on cycles 3,4,5 with the matching ram_q.
REQ-046 Scenario: rst_n asserted low 1 cycle after a grant -> no valid output, starve_cnt=0, and after release the first grant behaves as in REQ-041.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared definitions for the simple memory arbiter: tag encoding and default parameters.
package simple_pkg;

    localparam int DATA_W             = 16;
    localparam int ADDR_W             = 16;
    localparam int RAM_LAT_DEFAULT    = 1;
    localparam int STARVE_MAX_DEFAULT = 3;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2
    } tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Delay line that carries the owner of each RAM access until its read data returns.
module arb_tag_pipe
    import simple_pkg::*;
#(
    parameter int DEPTH = RAM_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [DEPTH];

    // Reset flushes every in-flight tag so no stale valid can escape after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/simple_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one pipelined RAM; data has priority unless
// fetch has been denied STARVE_MAX cycles in a row.
module simple_mem_arbiter
    import simple_pkg::*;
#(
    parameter int RAM_LAT    = RAM_LAT_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_stall,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  r_starve_cnt;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              w_starved;
    logic              w_grant_if;
    logic              w_grant_d;
    tag_t              w_tag_in;
    tag_t              w_tag_out;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    assign w_starved  = (r_starve_cnt == STARVE_TOP);
    assign w_grant_if = rst_n & if_req & (~d_req | w_starved);
    assign w_grant_d  = rst_n & d_req & ~w_grant_if;

    assign if_stall = if_req & ~w_grant_if;
    assign d_stall  = d_req & ~w_grant_d;

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!if_req || w_grant_if) begin
            w_starve_nxt = '0;
        end else if (!w_starved) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        ram_addr = r_last_addr;
        w_tag_in = TAG_NONE;
        if (w_grant_if) begin
            ram_addr = if_addr;
            w_tag_in = TAG_IF;
        end else if (w_grant_d) begin
            ram_addr = d_addr;
            w_tag_in = TAG_D;
        end
    end

    assign ram_wdata = d_wdata;
    assign ram_wren  = w_grant_d & d_we;

    // Idle cycles keep the address bus parked on the last granted address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else if (w_grant_if || w_grant_d) begin
            r_last_addr <= ram_addr;
        end
    end

    arb_tag_pipe #(
        .DEPTH (RAM_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign if_valid = (w_tag_out == TAG_IF);
    assign d_valid  = (w_tag_out == TAG_D);
    assign if_rdata = if_valid ? ram_q : '0;
    assign d_rdata  = d_valid  ? ram_q : '0;

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Directed bench: one arbiter with RAM_LAT=1 and one with RAM_LAT=3 share the requester inputs.
module tb_simple_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;

    logic        if_stall1, if_valid1, d_stall1, d_valid1, ram_wren1;
    logic [15:0] if_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_q1;
    logic        if_stall3, if_valid3, d_stall3, d_valid3, ram_wren3;
    logic [15:0] if_rdata3, d_rdata3, ram_addr3, ram_wdata3, ram_q3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simple_mem_arbiter u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall1),
        .if_valid(if_valid1), .if_rdata(if_rdata1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall1), .d_valid(d_valid1), .d_rdata(d_rdata1),
        .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wren(ram_wren1), .ram_q(ram_q1)
    );

    simple_mem_arbiter #(.RAM_LAT(3), .STARVE_MAX(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall3),
        .if_valid(if_valid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_stall(d_stall3), .d_valid(d_valid3), .d_rdata(d_rdata3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_wren(ram_wren3), .ram_q(ram_q3)
    );

    // RAM models: unwritten words read as addr ^ 16'hA5A5.
    bit [15:0] wmem1 [0:65535];
    bit        wval1 [0:65535];
    bit [15:0] wmem3 [0:65535];
    bit        wval3 [0:65535];
    logic [15:0] q3a, q3b;

    always @(posedge clk) begin
        if (ram_wren1) begin
            wmem1[ram_addr1] <= ram_wdata1;
            wval1[ram_addr1] <= 1'b1;
        end
        ram_q1 <= wval1[ram_addr1] ? wmem1[ram_addr1] : (ram_addr1 ^ 16'hA5A5);
    end

    always @(posedge clk) begin
        if (ram_wren3) begin
            wmem3[ram_addr3] <= ram_wdata3;
            wval3[ram_addr3] <= 1'b1;
        end
        q3a    <= wval3[ram_addr3] ? wmem3[ram_addr3] : (ram_addr3 ^ 16'hA5A5);
        q3b    <= q3a;
        ram_q3 <= q3b;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    initial begin
        // Reset held with both requesters active: nothing may be granted.
        rst_n   = 1'b0;
        if_req  = 1'b1; if_addr = 16'h0011;
        d_req   = 1'b1; d_we    = 1'b1; d_addr = 16'h00FF; d_wdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        chk("rst_ram_wren", ram_wren1, 16'h0);
        chk("rst_ram_addr", ram_addr1, 16'h0000);
        chk("rst_if_valid", if_valid1, 16'h0);
        chk("rst_d_valid",  d_valid1,  16'h0);
        chk("rst_if_rdata", if_rdata1, 16'h0000);
        chk("rst_d_rdata",  d_rdata1,  16'h0000);
        chk("rst_if_stall", if_stall1, 16'h1);
        chk("rst_d_stall",  d_stall1,  16'h1);

        step(); rst_n = 1'b1; idle();
        @(negedge clk);
        chk("rel_ram_addr", ram_addr1, 16'h0000);
        chk("rel_if_valid", if_valid1, 16'h0);

        // Fetch only.
        step(); if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        chk("s41_if_stall", if_stall1, 16'h0);
        chk("s41_ram_addr", ram_addr1, 16'h0010);
        chk("s41_ram_wren", ram_wren1, 16'h0);
        step(); idle();
        @(negedge clk);
        chk("s41_if_valid", if_valid1, 16'h1);
        chk("s41_if_rdata", if_rdata1, 16'hA5B5);
        chk("s41_hold_addr", ram_addr1, 16'h0010);
        chk("s41_d_valid", d_valid1, 16'h0);
        step();
        @(negedge clk);
        chk("s41_pulse_end", if_valid1, 16'h0);

        // Collision: data wins, fetch follows.
        step(); if_req = 1'b1; if_addr = 16'h0020; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk);
        chk("s42_d_stall",  d_stall1,  16'h0);
        chk("s42_if_stall", if_stall1, 16'h1);
        chk("s42_ram_addr", ram_addr1, 16'h0040);
        step(); d_req = 1'b0;
        @(negedge clk);
        chk("s42_d_valid",  d_valid1,  16'h1);
        chk("s42_d_rdata",  d_rdata1,  16'hA5E5);
        chk("s42_if_grant", if_stall1, 16'h0);
        chk("s42_if_addr",  ram_addr1, 16'h0020);
        step(); idle();
        @(negedge clk);
        chk("s42_if_valid", if_valid1, 16'h1);
        chk("s42_if_rdata", if_rdata1, 16'hA585);
        chk("s42_d_end",    d_valid1,  16'h0);

        // Starvation: fetch forced through in the 4th cycle.
        for (int i = 1; i <= 6; i++) begin
            step(); if_req = 1'b1; if_addr = 16'h0030; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
            @(negedge clk);
            chk("s43_if_stall", if_stall1, 16'(i != 4));
            chk("s43_d_stall",  d_stall1,  16'(i == 4));
            chk("s43_if_valid", if_valid1, 16'(i == 5));
            chk("s43_d_valid",  d_valid1,  16'(i >= 2 && i != 5));
            if (i == 4) chk("s43_ram_addr", ram_addr1, 16'h0030);
            if (i == 5) chk("s43_if_rdata", if_rdata1, 16'hA595);
        end
        step(); idle();
        @(negedge clk);
        chk("s43_last_d_valid", d_valid1, 16'h1);
        chk("s43_last_if_valid", if_valid1, 16'h0);

        // Write then read back the same word.
        step(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0005; d_wdata = 16'h1234;
        @(negedge clk);
        chk("s44_wren",  ram_wren1,  16'h1);
        chk("s44_wdata", ram_wdata1, 16'h1234);
        chk("s44_wstall", d_stall1,  16'h0);
        step(); d_we = 1'b0;
        @(negedge clk);
        chk("s44_wren_off", ram_wren1, 16'h0);
        chk("s44_wack",     d_valid1,  16'h1);
        step(); idle();
        @(negedge clk);
        chk("s44_rvalid", d_valid1, 16'h1);
        chk("s44_rdata",  d_rdata1, 16'h1234);
        step();
        @(negedge clk);
        chk("s44_rvalid_end", d_valid1, 16'h0);

        // Build starvation, then reset one cycle after a data grant.
        step(); if_req = 1'b1; if_addr = 16'h0060; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0070;
        @(negedge clk);
        chk("s46_pre_stall1", if_stall1, 16'h1);
        step();
        @(negedge clk);
        chk("s46_pre_stall2", if_stall1, 16'h1);
        chk("s46_pre_addr",   ram_addr1, 16'h0070);
        step(); rst_n = 1'b0;
        @(negedge clk);
        chk("s46_rst_d_valid", d_valid1,  16'h0);
        chk("s46_rst_addr",    ram_addr1, 16'h0000);
        chk("s46_rst_wren",    ram_wren1, 16'h0);
        step();
        @(negedge clk);
        chk("s46_rst_d_valid2", d_valid1, 16'h0);
        step(); rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("s46_post_if_stall", if_stall1, 16'(k != 4));
            chk("s46_post_d_valid",  d_valid1,  16'(k >= 2));
            chk("s46_post_if_valid", if_valid1, 16'h0);
            step();
        end
        idle();
        @(negedge clk);
        chk("s46_post_fetch_valid", if_valid1, 16'h1);
        chk("s46_post_fetch_rdata", if_rdata1, 16'hA5C5);
        step(); if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        chk("s46_f_stall", if_stall1, 16'h0);
        chk("s46_f_addr",  ram_addr1, 16'h0010);
        step(); idle();
        @(negedge clk);
        chk("s46_f_valid", if_valid1, 16'h1);
        chk("s46_f_rdata", if_rdata1, 16'hA5B5);
        repeat (3) step();

        // RAM_LAT=3: IF, D, IF back to back.
        step(); if_req = 1'b1; if_addr = 16'h0100;
        @(negedge clk);
        chk("s45_c0_if_stall", if_stall3, 16'h0);
        chk("s45_c0_addr",     ram_addr3, 16'h0100);
        chk("s45_c0_if_valid", if_valid3, 16'h0);
        chk("s45_c0_d_valid",  d_valid3,  16'h0);
        step(); if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        @(negedge clk);
        chk("s45_c1_d_stall", d_stall3,  16'h0);
        chk("s45_c1_addr",    ram_addr3, 16'h0200);
        step(); d_req = 1'b0; if_req = 1'b1; if_addr = 16'h0300;
        @(negedge clk);
        chk("s45_c2_if_valid", if_valid3, 16'h0);
        chk("s45_c2_d_valid",  d_valid3,  16'h0);
        step(); idle();
        @(negedge clk);
        chk("s45_c3_if_valid", if_valid3, 16'h1);
        chk("s45_c3_if_rdata", if_rdata3, 16'hA4A5);
        chk("s45_c3_d_valid",  d_valid3,  16'h0);
        step();
        @(negedge clk);
        chk("s45_c4_d_valid",  d_valid3,  16'h1);
        chk("s45_c4_d_rdata",  d_rdata3,  16'hA7A5);
        chk("s45_c4_if_valid", if_valid3, 16'h0);
        step();
        @(negedge clk);
        chk("s45_c5_if_valid", if_valid3, 16'h1);
        chk("s45_c5_if_rdata", if_rdata3, 16'hA6A5);
        step();
        @(negedge clk);
        chk("s45_c6_if_valid", if_valid3, 16'h0);
        chk("s45_c6_d_valid",  d_valid3,  16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
